// File: rtl/cl_frame_tx.sv
// cl_frame_tx: CameraLink-style frame transmitter turning 4-pixel words into FVAL/LVAL/DVAL timing.
// Define CL_TX_TESTPAT_EN to add the testMode input and the internal ramp-pattern generator.
module cl_frame_tx #(
  parameter int FV_LEAD = 4,
  parameter int FV_TAIL = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        send_frame,
  input  logic [15:0] imageWidth,
  input  logic [15:0] imageHeight,
  input  logic [15:0] hBlank,
`ifdef CL_TX_TESTPAT_EN
  input  logic        testMode,
`endif
  input  logic [47:0] s_pixel,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        frame_valid_cl,
  output logic        line_valid_cl,
  output logic        new_frame_cl,
  output logic        pixel_vld_cl,
  output logic [47:0] pixel_cl,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] underrun_cnt
);

  typedef enum logic [2:0] {IDLE, LEAD, LINE, HBLANK, TAIL} state_t;

  localparam logic [15:0] LEAD_LAST = 16'(FV_LEAD - 1);
  localparam logic [15:0] TAIL_LAST = 16'(FV_TAIL - 1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t      state, state_nx;
  logic [15:0] width_q, height_q, hblank_q;
  logic [15:0] width_nx, height_nx, hblank_nx;
  logic [15:0] col_cnt, line_cnt, phase_cnt;
  logic [15:0] col_nx, line_nx, phase_nx;
  logic [15:0] underrun_nx;
  logic        ready_nx, fv_nx, lv_nx, nf_nx, dv_nx, done_nx, busy_nx;
  logic [47:0] pixel_nx;
  logic        cfg_ok, in_valid, xfer, ready_en;
  logic [47:0] in_word;

`ifdef CL_TX_TESTPAT_EN
  logic        test_q, test_nx;
  logic [11:0] pat_base;

  // Ramp pattern shares the capture path's lane ordering: n, n+2, n+1, n+3 from LSB up.
  assign pat_base = 12'(line_cnt + col_cnt);
  assign in_valid = test_q | (s_valid & s_ready);
  assign in_word  = test_q ? {pat_base + 12'd3, pat_base + 12'd1, pat_base + 12'd2, pat_base}
                           : s_pixel;
  assign ready_en = ~test_q;
`else
  assign in_valid = s_valid & s_ready;
  assign in_word  = s_pixel;
  assign ready_en = 1'b1;
`endif

  assign cfg_ok = (imageWidth >= 16'd4) && (imageWidth[1:0] == 2'b00) && (imageHeight != 16'd0);
  assign xfer   = (state == LINE) && in_valid;

  always_comb begin
    state_nx    = state;
    width_nx    = width_q;
    height_nx   = height_q;
    hblank_nx   = hblank_q;
    col_nx      = col_cnt;
    line_nx     = line_cnt;
    phase_nx    = phase_cnt;
    underrun_nx = underrun_cnt;
    pixel_nx    = pixel_cl;
    ready_nx    = 1'b0;
    fv_nx       = 1'b0;
    lv_nx       = 1'b0;
    nf_nx       = 1'b0;
    dv_nx       = 1'b0;
    done_nx     = 1'b0;
`ifdef CL_TX_TESTPAT_EN
    test_nx     = test_q;
`endif
    case (state)
      IDLE: begin
        if (send_frame && cfg_ok) begin
          width_nx    = imageWidth;
          height_nx   = imageHeight;
          hblank_nx   = hBlank;
`ifdef CL_TX_TESTPAT_EN
          test_nx     = testMode;
`endif
          col_nx      = 16'd0;
          line_nx     = 16'd0;
          phase_nx    = LEAD_LAST;
          underrun_nx = 16'd0;
          fv_nx       = 1'b1;
          nf_nx       = 1'b1;
          state_nx    = LEAD;
        end
      end
      LEAD: begin
        fv_nx = 1'b1;
        if (phase_cnt == 16'd0) begin
          state_nx = LINE;
          ready_nx = ready_en;
        end else begin
          phase_nx = phase_cnt - 16'd1;
        end
      end
      LINE: begin
        // LVAL/DVAL are registered from this state, so both land one cycle after the transfer.
        fv_nx = 1'b1;
        lv_nx = 1'b1;
        if (xfer) begin
          dv_nx    = 1'b1;
          pixel_nx = in_word;
          if (col_cnt == width_q - 16'd4) begin
            col_nx  = 16'd0;
            line_nx = line_cnt + 16'd1;
            if (line_cnt == height_q - 16'd1) begin
              state_nx = TAIL;
              phase_nx = TAIL_LAST;
            end else begin
              state_nx = HBLANK;
              phase_nx = (hblank_q == 16'd0) ? 16'd0 : hblank_q - 16'd1;
            end
          end else begin
            col_nx   = col_cnt + 16'd4;
            ready_nx = ready_en;
          end
        end else begin
          ready_nx    = ready_en;
          underrun_nx = sat_inc(underrun_cnt);
        end
      end
      HBLANK: begin
        fv_nx = 1'b1;
        if (phase_cnt == 16'd0) begin
          state_nx = LINE;
          ready_nx = ready_en;
        end else begin
          phase_nx = phase_cnt - 16'd1;
        end
      end
      TAIL: begin
        if (phase_cnt == 16'd0) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else begin
          fv_nx    = 1'b1;
          phase_nx = phase_cnt - 16'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
    busy_nx = (state_nx != IDLE);
  end

  // Output register stage: every port is a flop, cleared asynchronously.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= IDLE;
      width_q        <= 16'd0;
      height_q       <= 16'd0;
      hblank_q       <= 16'd0;
      col_cnt        <= 16'd0;
      line_cnt       <= 16'd0;
      phase_cnt      <= 16'd0;
      underrun_cnt   <= 16'd0;
      pixel_cl       <= 48'd0;
      s_ready        <= 1'b0;
      frame_valid_cl <= 1'b0;
      line_valid_cl  <= 1'b0;
      new_frame_cl   <= 1'b0;
      pixel_vld_cl   <= 1'b0;
      frame_done     <= 1'b0;
      busy           <= 1'b0;
`ifdef CL_TX_TESTPAT_EN
      test_q         <= 1'b0;
`endif
    end else begin
      state          <= state_nx;
      width_q        <= width_nx;
      height_q       <= height_nx;
      hblank_q       <= hblank_nx;
      col_cnt        <= col_nx;
      line_cnt       <= line_nx;
      phase_cnt      <= phase_nx;
      underrun_cnt   <= underrun_nx;
      pixel_cl       <= pixel_nx;
      s_ready        <= ready_nx;
      frame_valid_cl <= fv_nx;
      line_valid_cl  <= lv_nx;
      new_frame_cl   <= nf_nx;
      pixel_vld_cl   <= dv_nx;
      frame_done     <= done_nx;
      busy           <= busy_nx;
`ifdef CL_TX_TESTPAT_EN
      test_q         <= test_nx;
`endif
    end
  end

endmodule

// File: doc/cl_frame_tx.md
# cl_frame_tx

- Camera-side CameraLink frame transmitter: drains 48-bit, 4-pixel words (4×12-bit lanes) from an upstream buffer over a valid/ready handshake.
- Emits CameraLink-style frame timing: frame valid, line valid, data valid and a new-frame pulse, with programmable blanking.
- It is the sending end of the pixel interface consumed by the capture controller. It feeds the serializer, or loops back to the capture path for bench and board self-test.

## Interface
Parameters:
- FV_LEAD, 4: cycles of frame_valid_cl high before the first line (≥1).
- FV_TAIL, 4: cycles of frame_valid_cl high after the last line (≥1).

Ports:
- sys_clk  in  1  single clock.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- send_frame  in  1  start pulse.
- imageWidth  in  16  pixels per line, multiple of 4, ≥4.
- imageHeight  in  16  lines per frame, ≥1.
- hBlank  in  16  line_valid low cycles between lines; 0 is treated as 1.
- s_pixel  in  48  input word. Lane mapping: [11:0] pixel n, [35:24] n+1, [23:12] n+2, [47:36] n+3.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid & s_ready.
- frame_valid_cl  out  1  FVAL.
- line_valid_cl  out  1  LVAL.
- new_frame_cl  out  1  one-cycle pulse on the FVAL rising edge.
- pixel_vld_cl  out  1  DVAL.
- pixel_cl  out  48  pixel word.
- busy  out  1  state ≠ IDLE.
- frame_done  out  1  one-cycle pulse when the frame ends.
- underrun_cnt  out  16  saturating count of LINE cycles with no transfer.

## Operation
- All outputs are registered. Reset value of every output is 0; s_ready is 0.
- **IDLE**
  - send_frame is ignored if imageWidth<4, imageWidth[1:0]≠0, or imageHeight==0.
  - Otherwise imageWidth, imageHeight and hBlank are latched, underrun_cnt is cleared, and the state moves to LEAD.
- **LEAD**
  - On entry, frame_valid_cl=1 and new_frame_cl=1 for that first cycle only.
  - Lasts FV_LEAD cycles, then moves to LINE.
- **LINE**
  - line_valid_cl=1 and s_ready=1.
  - On each transfer: pixel_cl is loaded with s_pixel, pixel_vld_cl=1, and colCnt advances by 4.
  - On a cycle with no transfer: pixel_vld_cl=0, pixel_cl holds, line_valid_cl stays 1, and underrun_cnt increments (saturating at 0xFFFF).
  - On the transfer where colCnt==imageWidth-4: colCnt returns to 0 and lineCnt increments.
  - After that transfer: if lineCnt==imageHeight-1, move to TAIL; otherwise move to HBLANK.
- **HBLANK**
  - line_valid_cl=0, s_ready=0.
  - Lasts max(hBlank,1) cycles, then returns to LINE.
- **TAIL**
  - frame_valid_cl=1, line_valid_cl=0.
  - Lasts FV_TAIL cycles.
  - On exit: frame_valid_cl=0, frame_done=1 for one cycle, state returns to IDLE.
- send_frame while busy is ignored. There is no queueing.
- Counters are 16-bit; compares use the latched values. Input ports may change mid-frame without effect.
- Async reset mid-frame: all outputs drop to 0 immediately and the state returns to IDLE. The partially sent frame is abandoned, and the receiver sees FVAL fall without a complete frame.

## Timing
- Cycle T: send_frame sampled high in IDLE.
- T+1: frame_valid_cl=1 and new_frame_cl=1.
- T+1+FV_LEAD: first LINE cycle; s_ready=1 there.
- Handshake latency: a transfer in cycle N gives pixel_vld_cl=1 and valid pixel_cl in cycle N+1.
- line_valid_cl is delayed one cycle to stay aligned with the data, so LVAL frames exactly the DVAL words of its line.
- s_ready falls in the cycle after the last transfer of a line. No word is accepted beyond imageWidth/4 per line.
- Total frame length with no stalls: FV_LEAD + H·(W/4) + (H-1)·max(hBlank,1) + FV_TAIL cycles of FVAL, with W=imageWidth and H=imageHeight.
- frame_done is asserted in the first cycle with frame_valid_cl=0.
- Minimum IDLE gap is 1 cycle: send_frame is accepted in the same cycle frame_done is high.

## Configuration
- CL_TX_TESTPAT_EN defined:
  - Adds input testMode, sampled at send_frame.
  - When testMode=1, the internal generator replaces s_pixel/s_valid: valid every LINE cycle, and s_ready is held 0.
  - Lanes: [11:0]=line+col, [35:24]=line+col+1, [23:12]=line+col+2, [47:36]=line+col+3, truncated to 12 bits. col is the first pixel index of the word.
  - This matches the capture path's self-test pattern.
- CL_TX_TESTPAT_EN undefined:
  - No testMode port and no generator logic; data comes only from s_pixel.

## Test plan
- **Basic frame:** W=8, H=2, hBlank=3, s_valid=1, words A,B,C,D.
  - new_frame_cl at T+1; DVAL words A,B, then LVAL low for 3 cycles, then C,D.
  - frame_done 5 cycles after D (FV_TAIL=4, plus 1); frame is 15 FVAL cycles; underrun_cnt=0.
- **Stall:** W=16, s_valid low for 5 cycles mid-line.
  - LVAL stays high; DVAL gap of 5; underrun_cnt=5; exactly 4 words per line.
- **Illegal configuration:** send_frame with W=6, then W=0, then H=0.
  - No FVAL, busy stays 0.
- **Busy:** send_frame again during LINE is ignored.
  - Exactly one new_frame_cl pulse; back-to-back send_frame in the frame_done cycle starts the next frame.
- **Reset mid-frame:** sys_rst_n low during LINE.
  - All outputs 0 asynchronously; after release, a full W=4, H=1 frame is sent correctly.
- **Test pattern (CL_TX_TESTPAT_EN, testMode=1, W=8, H=2):**
  - Words 0x003_001_002_000, 0x007_005_006_004, 0x004_002_003_001, 0x008_006_007_005 (hex [47:36]_[35:24]_[23:12]_[11:0]).
  - s_ready stays 0 throughout.
